mul_div_sequencer: RTL and testbench
====================================

# mul_div_sequencer

Multi-cycle multiply/divide sequencer that time-shares the execute-stage ALU with the integer pipeline. While idle it passes the pipeline's ALU operands straight through. After a start it takes ownership of the ALU and runs UMUL, SMUL or UDIV as a series of one-ALU-op-per-cycle steps using the ALU's ADDcc/SUB/SUBcc/SUBX codes. It stalls the pipeline until the 64-bit result is ready.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- clk  in  1  the only clock; all state changes on its rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request to begin an operation; sampled only in IDLE
- op  in  2  00 UMUL, 01 SMUL, 10 UDIV, 11 reserved (start ignored)
- src_a  in  32  multiplicand / dividend
- src_b  in  32  multiplier / divisor
- pipe_a, pipe_b  in  32 each  pipeline ALU operands
- pipe_op3  in  6  pipeline ALU opcode
- pipe_cin  in  1  pipeline ALU carry-in
- alu_a, alu_b  out  32 each  ALU operands (muxed)
- alu_op3  out  6  ALU opcode (muxed)
- alu_cin  out  1  ALU carry-in (muxed)
- alu_out  in  32  ALU result, combinational, same cycle
- alu_c  in  1  ALU C flag: carry-out for ADDcc, borrow for SUBcc
- busy  out  1  high whenever state is not IDLE
- stall  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse in DONE
- div_zero  out  1  set with done when UDIV has divisor 0; cleared at the next accepted start
- result_hi  out  32  MUL: product[63:32]; DIV: remainder
- result_lo  out  32  MUL: product[31:0]; DIV: quotient

## Operation
- States: IDLE, NEG_A, NEG_B, STEP, FIX_LO, FIX_HI, DONE.
- Reset: state IDLE; count, acc, mq, mcand, sign, borrow, result_hi, result_lo, div_zero, done all 0. A reset during any state aborts the operation without completing it.
- ALU mux:
  - In IDLE and DONE, the alu_* outputs equal the pipe_* inputs.
  - In all other states, the sequencer drives the alu_* outputs. alu_cin is 0 except in FIX_HI.
- IDLE:
  - On start with op = 11, nothing happens.
  - On start with a valid op: capture src_a, src_b and op, set sign = src_a[31] ^ src_b[31] (SMUL only), set count = 0, clear div_zero.
  - Next state: UDIV with src_b = 0 goes to DONE with div_zero = 1, result_hi = src_a, result_lo = 0xFFFFFFFF. SMUL goes to NEG_A. UMUL and UDIV go to STEP.
  - Starts arriving outside IDLE are ignored.
- NEG_A / NEG_B (SMUL only):
  - ALU drives 0 SUB operand (op3 000100).
  - The register is replaced with alu_out only if that operand's sign bit is set.
  - NEG_A, then NEG_B, then STEP.
- MUL STEP (acc starts at 0, mq = multiplier):
  - ALU drives a = acc, b = mq[0] ? mcand : 0, op3 010000.
  - Update acc <= {alu_c, alu_out[31:1]} and mq <= {alu_out[0], mq[31:1]}.
- DIV STEP (acc starts at 0, mq = dividend):
  - ALU drives a = {acc[30:0], mq[31]}, b = divisor, op3 010100.
  - Compute ge = acc[31] | ~alu_c.
  - Update acc <= ge ? alu_out : alu_a and mq <= {mq[30:0], ge}.
- STEP control: count increments every STEP cycle. After the cycle with count = 31, go to FIX_LO for SMUL, otherwise to DONE.
- FIX_LO:
  - If sign: ALU drives 0 SUBcc mq, then mq <= alu_out and borrow <= alu_c.
  - If not sign: no change.
  - Always go to FIX_HI.
- FIX_HI:
  - If sign: ALU drives 0 SUBX acc (op3 001100) with alu_cin = borrow, then acc <= alu_out.
  - Always go to DONE.
- Result load: result_hi/result_lo load from acc/mq on entry to DONE and hold until the next accepted start.
- DONE: done = 1 for one cycle, then IDLE. A start in the DONE cycle is ignored.

## Timing
- Start accepted at edge T.
- UMUL/UDIV: STEP occupies T+1..T+32, DONE at T+33.
- SMUL: NEG_A at T+1, NEG_B at T+2, STEP T+3..T+34, FIX_LO T+35, FIX_HI T+36, DONE at T+37.
- Divide by zero: DONE at T+1.
- stall is a combinational decode of state. It is high from T+1 through the cycle before DONE.
- result_* are registered outputs and are valid in the DONE cycle.
- ALU path: one combinational pass per cycle; alu_out and alu_c are sampled at the end of the same cycle.

## Test plan
- UMUL 0xFFFFFFFF × 0xFFFFFFFF -> result_hi = 0xFFFFFFFE, result_lo = 0x00000001; done in exactly cycle T+33; stall high for cycles T+1..T+32.
- SMUL −3 × 7 -> result_hi = 0xFFFFFFFF, result_lo = 0xFFFFFFEB at T+37. SMUL 0x80000000 × 0x80000000 -> result_hi = 0x40000000, result_lo = 0.
- UDIV 100 / 7 -> result_lo = 14, result_hi = 2 at T+33. UDIV 0xFFFFFFFF / 1 -> result_lo = 0xFFFFFFFF, result_hi = 0.
- UDIV 5 / 0 -> done at T+1, div_zero = 1, result_lo = 0xFFFFFFFF, result_hi = 5, stall never asserted.
- Arbitration: in IDLE, random pipe_* values appear on alu_* unchanged. A start pulsed at T+10 of a running UMUL is ignored (result unchanged, done only at T+33). op = 11 leaves busy low.
- rst_n low at T+15 of an SMUL -> next cycle state IDLE, busy = 0, done = 0, results = 0, alu_* follow pipe_*.

Source files
------------

// File: rtl/mul_div_sequencer.sv
// Multi-cycle UMUL/SMUL/UDIV sequencer that borrows the execute-stage ALU,
// running one ALU operation per cycle and stalling the pipeline until done.
module mul_div_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] pipe_a,
  input  logic [31:0] pipe_b,
  input  logic [5:0]  pipe_op3,
  input  logic        pipe_cin,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_op3,
  output logic        alu_cin,
  input  logic [31:0] alu_out,
  input  logic        alu_c,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo
);

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_STEP, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  localparam logic [1:0] OP_UMUL = 2'b00;
  localparam logic [1:0] OP_SMUL = 2'b01;
  localparam logic [1:0] OP_UDIV = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [5:0] ALU_SUB   = 6'b000100;
  localparam logic [5:0] ALU_ADDCC = 6'b010000;
  localparam logic [5:0] ALU_SUBCC = 6'b010100;
  localparam logic [5:0] ALU_SUBX  = 6'b001100;

  state_t      state, state_nxt;
  logic [4:0]  count, count_nxt;
  logic [31:0] acc, acc_nxt;
  logic [31:0] mq, mq_nxt;
  logic [31:0] mcand, mcand_nxt;
  logic [1:0]  op_r, op_nxt;
  logic        sign, sign_nxt;
  logic        borrow, borrow_nxt;
  logic        dz_nxt;
  logic        ge;

  logic [31:0] seq_a, seq_b;
  logic [5:0]  seq_op3;
  logic        seq_cin;
  logic        pass;

  // ALU operands the sequencer presents; depends only on registered state.
  always_comb begin
    seq_a   = 32'd0;
    seq_b   = 32'd0;
    seq_op3 = 6'd0;
    seq_cin = 1'b0;
    case (state)
      S_NEG_A: begin
        seq_b   = mcand;
        seq_op3 = ALU_SUB;
      end
      S_NEG_B: begin
        seq_b   = mq;
        seq_op3 = ALU_SUB;
      end
      S_STEP: begin
        if (op_r == OP_UDIV) begin
          seq_a   = {acc[30:0], mq[31]};
          seq_b   = mcand;
          seq_op3 = ALU_SUBCC;
        end else begin
          seq_a   = acc;
          seq_b   = mq[0] ? mcand : 32'd0;
          seq_op3 = ALU_ADDCC;
        end
      end
      S_FIX_LO: begin
        if (sign) begin
          seq_b   = mq;
          seq_op3 = ALU_SUBCC;
        end
      end
      S_FIX_HI: begin
        if (sign) begin
          seq_b   = acc;
          seq_op3 = ALU_SUBX;
          seq_cin = borrow;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    acc_nxt    = acc;
    mq_nxt     = mq;
    mcand_nxt  = mcand;
    op_nxt     = op_r;
    sign_nxt   = sign;
    borrow_nxt = borrow;
    dz_nxt     = div_zero;
    ge         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && op != OP_RSVD) begin
          op_nxt     = op;
          count_nxt  = 5'd0;
          dz_nxt     = 1'b0;
          borrow_nxt = 1'b0;
          sign_nxt   = (op == OP_SMUL) & (src_a[31] ^ src_b[31]);
          acc_nxt    = 32'd0;
          if (op == OP_UDIV) begin
            mcand_nxt = src_b;
            mq_nxt    = src_a;
          end else begin
            mcand_nxt = src_a;
            mq_nxt    = src_b;
          end
          if (op == OP_UDIV && src_b == 32'd0) begin
            // Divide by zero finishes immediately with remainder = dividend.
            dz_nxt    = 1'b1;
            acc_nxt   = src_a;
            mq_nxt    = 32'hFFFF_FFFF;
            state_nxt = S_DONE;
          end else if (op == OP_SMUL) begin
            state_nxt = S_NEG_A;
          end else begin
            state_nxt = S_STEP;
          end
        end
      end
      S_NEG_A: begin
        if (mcand[31]) mcand_nxt = alu_out;
        state_nxt = S_NEG_B;
      end
      S_NEG_B: begin
        if (mq[31]) mq_nxt = alu_out;
        state_nxt = S_STEP;
      end
      S_STEP: begin
        count_nxt = count + 5'd1;
        if (op_r == OP_UDIV) begin
          // acc[31] set means the shifted remainder exceeds 32 bits.
          ge      = acc[31] | ~alu_c;
          acc_nxt = ge ? alu_out : seq_a;
          mq_nxt  = {mq[30:0], ge};
        end else begin
          acc_nxt = {alu_c, alu_out[31:1]};
          mq_nxt  = {alu_out[0], mq[31:1]};
        end
        if (count == 5'd31)
          state_nxt = (op_r == OP_SMUL) ? S_FIX_LO : S_DONE;
      end
      S_FIX_LO: begin
        if (sign) begin
          mq_nxt     = alu_out;
          borrow_nxt = alu_c;
        end
        state_nxt = S_FIX_HI;
      end
      S_FIX_HI: begin
        if (sign) acc_nxt = alu_out;
        state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      count     <= 5'd0;
      acc       <= 32'd0;
      mq        <= 32'd0;
      mcand     <= 32'd0;
      op_r      <= OP_UMUL;
      sign      <= 1'b0;
      borrow    <= 1'b0;
      div_zero  <= 1'b0;
      result_hi <= 32'd0;
      result_lo <= 32'd0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      acc      <= acc_nxt;
      mq       <= mq_nxt;
      mcand    <= mcand_nxt;
      op_r     <= op_nxt;
      sign     <= sign_nxt;
      borrow   <= borrow_nxt;
      div_zero <= dz_nxt;
      if (state_nxt == S_DONE && state != S_DONE) begin
        result_hi <= acc_nxt;
        result_lo <= mq_nxt;
      end
    end
  end

  assign pass    = (state == S_IDLE) || (state == S_DONE);
  assign alu_a   = pass ? pipe_a   : seq_a;
  assign alu_b   = pass ? pipe_b   : seq_b;
  assign alu_op3 = pass ? pipe_op3 : seq_op3;
  assign alu_cin = pass ? pipe_cin : seq_cin;

  assign busy  = (state != S_IDLE);
  assign stall = !pass;
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer: models the shared ALU and checks
// timing, arbitration and results against plain-arithmetic expectations.
module tb_mul_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic [31:0] pipe_a, pipe_b;
  logic [5:0]  pipe_op3;
  logic        pipe_cin;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  alu_op3;
  logic        alu_cin;
  logic [31:0] alu_out;
  logic        alu_c;
  logic        busy, stall, done, div_zero;
  logic [31:0] result_hi, result_lo;

  int checks = 0;
  int errors = 0;

  mul_div_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_op3(pipe_op3), .pipe_cin(pipe_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op3(alu_op3), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_c(alu_c),
    .busy(busy), .stall(stall), .done(done), .div_zero(div_zero),
    .result_hi(result_hi), .result_lo(result_lo)
  );

  always #5 clk = ~clk;

  // Execute-stage ALU model: C is carry for ADDcc and borrow for SUBcc.
  always_comb begin
    alu_out = alu_a ^ alu_b;
    alu_c   = 1'b0;
    case (alu_op3)
      6'b010000: {alu_c, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      6'b000100: alu_out = alu_a - alu_b;
      6'b010100: {alu_c, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
      6'b001100: alu_out = alu_a - alu_b - {31'd0, alu_cin};
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rand_pipe();
    pipe_a   = $urandom;
    pipe_b   = $urandom;
    pipe_op3 = 6'($urandom_range(0, 63));
    pipe_cin = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_pass();
    chk("alu_a passthrough", alu_a, pipe_a);
    chk("alu_b passthrough", alu_b, pipe_b);
    chk("alu_op3 passthrough", {26'd0, alu_op3}, {26'd0, pipe_op3});
    chk("alu_cin passthrough", {31'd0, alu_cin}, {31'd0, pipe_cin});
  endtask

  // Reference: result and latency (cycles from acceptance to DONE), 0 = ignored.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output logic dz, output int lat);
    logic [63:0]        up;
    logic signed [63:0] sp, sa, sb;
    hi = 32'd0; lo = 32'd0; dz = 1'b0; lat = 0;
    case (o)
      2'b00: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32]; lo = up[31:0]; lat = 33;
      end
      2'b01: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = sa * sb;
        hi = sp[63:32]; lo = sp[31:0]; lat = 37;
      end
      2'b10: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1; lat = 1;
        end else begin
          hi = a % b; lo = a / b; lat = 33;
        end
      end
      default: lat = 0;
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int restart_at, input int rst_at,
                        input bit lit, input logic [31:0] lhi, input logic [31:0] llo);
    logic [31:0] mhi, mlo;
    logic        mdz;
    int          lat;
    model(o, a, b, mhi, mlo, mdz, lat);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b; rand_pipe();
    #1;
    chk("busy before start", {31'd0, busy}, 32'd0);
    chk_pass();
    if (lat == 0) begin
      for (int k = 1; k <= 2; k++) begin
        @(posedge clk); #1;
        start = 1'b0; rand_pipe();
        #1;
        chk("busy after reserved op", {31'd0, busy}, 32'd0);
        chk("done after reserved op", {31'd0, done}, 32'd0);
        chk_pass();
      end
      return;
    end
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      start = (k == restart_at);
      if (start) begin
        op = 2'($urandom_range(0, 2)); src_a = $urandom; src_b = $urandom;
      end
      rst_n = (k != rst_at);
      rand_pipe();
      #1;
      chk("busy", {31'd0, busy}, 32'd1);
      chk("stall", {31'd0, stall}, (k < lat) ? 32'd1 : 32'd0);
      chk("done", {31'd0, done}, (k == lat) ? 32'd1 : 32'd0);
      if (k == lat) begin
        chk_pass();
        chk("result_hi", result_hi, mhi);
        chk("result_lo", result_lo, mlo);
        chk("div_zero", {31'd0, div_zero}, {31'd0, mdz});
        if (lit) begin
          chk("result_hi literal", result_hi, lhi);
          chk("result_lo literal", result_lo, llo);
        end
      end
      if (k == rst_at) begin
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0; rand_pipe();
        #1;
        chk("busy after reset", {31'd0, busy}, 32'd0);
        chk("stall after reset", {31'd0, stall}, 32'd0);
        chk("done after reset", {31'd0, done}, 32'd0);
        chk("result_hi after reset", result_hi, 32'd0);
        chk("result_lo after reset", result_lo, 32'd0);
        chk("div_zero after reset", {31'd0, div_zero}, 32'd0);
        chk_pass();
        return;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; rand_pipe();
    #1;
    chk("busy after done", {31'd0, busy}, 32'd0);
    chk("done after done", {31'd0, done}, 32'd0);
    chk("result_hi held", result_hi, mhi);
    chk_pass();
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
    rand_pipe();
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset div_zero", {31'd0, div_zero}, 32'd0);
    chk("reset result_hi", result_hi, 32'd0);
    chk("reset result_lo", result_lo, 32'd0);
    chk_pass();
    rst_n = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7,         -1, -1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, -1, -1, 1'b1, 32'h4000_0000, 32'h0000_0000);
    run_op(2'b10, 32'd100,       32'd7,         -1, -1, 1'b1, 32'd2,         32'd14);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd1,         -1, -1, 1'b1, 32'd0,         32'hFFFF_FFFF);
    run_op(2'b10, 32'd5,         32'd0,         -1, -1, 1'b1, 32'd5,         32'hFFFF_FFFF);
    run_op(2'b00, 32'd12345,     32'd678,       10, -1, 1'b1, 32'd0,         32'd8369910);
    run_op(2'b00, 32'hDEAD_BEEF, 32'h1234_5678, 33, -1, 1'b0, 32'd0,         32'd0);
    run_op(2'b11, 32'd9,         32'd9,         -1, -1, 1'b0, 32'd0,         32'd0);
    run_op(2'b01, 32'hFFFF_FFF0, 32'd3,         -1, 15, 1'b0, 32'd0,         32'd0);

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, ($urandom_range(0, 3) == 0) ? 5 : -1, -1, 1'b0, 32'd0, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
